// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, opcodes, FSM states.
package alu_pkg;

    localparam int ALU_WIDTH = 4;
    localparam int OP_WIDTH  = 3;

    localparam logic [OP_WIDTH-1:0] OP_ADD = 3'b000;
    localparam logic [OP_WIDTH-1:0] OP_SUB = 3'b001;
    localparam logic [OP_WIDTH-1:0] OP_NOT = 3'b010;
    localparam logic [OP_WIDTH-1:0] OP_AND = 3'b011;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 3'b100;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 3'b101;
    localparam logic [OP_WIDTH-1:0] OP_CMP = 3'b110;
    localparam logic [OP_WIDTH-1:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// Two request channels and one response channel of the shared ALU.
// master: requesters plus response consumer; slave: the arbiter.
interface alu_share_arb_if
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = alu_pkg::ALU_WIDTH,
    parameter int OP_WIDTH  = alu_pkg::OP_WIDTH
);
    logic                 r0_valid;
    logic                 r0_ready;
    logic [OP_WIDTH-1:0]  r0_op;
    logic [ALU_WIDTH-1:0] r0_a;
    logic [ALU_WIDTH-1:0] r0_b;

    logic                 r1_valid;
    logic                 r1_ready;
    logic [OP_WIDTH-1:0]  r1_op;
    logic [ALU_WIDTH-1:0] r1_a;
    logic [ALU_WIDTH-1:0] r1_b;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [ALU_WIDTH-1:0] rsp_result;
    logic                 rsp_carry;
    logic                 rsp_overflow;

    modport master (
        output r0_valid, r0_op, r0_a, r0_b,
        output r1_valid, r1_op, r1_a, r1_b,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
        output rsp_ready
    );

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b,
        input  r1_valid, r1_op, r1_a, r1_b,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_overflow,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: one shared add/sub path feeds carry/overflow for
// every opcode, plus the logic ops and the compare/equality flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = alu_pkg::ALU_WIDTH,
    parameter int OP_WIDTH  = alu_pkg::OP_WIDTH
) (
    input  logic [OP_WIDTH-1:0]  op_i,
    input  logic [ALU_WIDTH-1:0] a_i,
    input  logic [ALU_WIDTH-1:0] b_i,
    output logic [ALU_WIDTH-1:0] result_o,
    output logic                 carry_o,
    output logic                 overflow_o
);
    localparam logic [ALU_WIDTH-1:0] ONE = {{(ALU_WIDTH-1){1'b0}}, 1'b1};

    logic [ALU_WIDTH-1:0] bt;
    logic [ALU_WIDTH:0]   sum_ext;
    logic [ALU_WIDTH-1:0] sum;

    // Add/sub path: B is two's-complement negated for every opcode but ADD.
    always_comb begin
        bt         = (op_i == OP_ADD) ? b_i : (~b_i + ONE);
        sum_ext    = {1'b0, a_i} + {1'b0, bt};
        sum        = sum_ext[ALU_WIDTH-1:0];
        carry_o    = sum_ext[ALU_WIDTH];
        overflow_o = (a_i[ALU_WIDTH-1] == bt[ALU_WIDTH-1]) &&
                     (sum[ALU_WIDTH-1] != a_i[ALU_WIDTH-1]);
    end

    // Result select per opcode.
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD, OP_SUB: result_o = sum;
            OP_NOT:         result_o = ~a_i;
            OP_AND:         result_o = a_i & b_i;
            OP_OR:          result_o = a_i | b_i;
            OP_XOR:         result_o = a_i ^ b_i;
            OP_CMP:         result_o = {{(ALU_WIDTH-1){1'b0}}, sum[ALU_WIDTH-1]};
            OP_EQ:          result_o = {{(ALU_WIDTH-1){1'b0}}, (sum == '0)};
            default:        result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters.
// IDLE accepts one operation, EXEC registers the ALU result, RESP holds the
// response until the consumer takes it.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = alu_pkg::ALU_WIDTH,
    parameter int OP_WIDTH  = alu_pkg::OP_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    alu_share_arb_if.slave bus
);
    state_e               state_q;
    logic                 ptr_q;
    logic [OP_WIDTH-1:0]  op_q;
    logic [ALU_WIDTH-1:0] a_q;
    logic [ALU_WIDTH-1:0] b_q;
    logic                 id_q;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [ALU_WIDTH-1:0] rsp_result_q;
    logic                 rsp_carry_q;
    logic                 rsp_overflow_q;

    logic                 grant0_d;
    logic                 grant1_d;
    logic [ALU_WIDTH-1:0] core_result;
    logic                 core_carry;
    logic                 core_overflow;

    // Grant decision: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (!rst && state_q == ST_IDLE) begin
            if (bus.r0_valid && (!bus.r1_valid || !ptr_q)) begin
                grant0_d = 1'b1;
            end else if (bus.r1_valid) begin
                grant1_d = 1'b1;
            end
        end
    end

    assign bus.r0_ready     = grant0_d;
    assign bus.r1_ready     = grant1_d;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_overflow = rsp_overflow_q;

    alu_core #(
        .ALU_WIDTH (ALU_WIDTH),
        .OP_WIDTH  (OP_WIDTH)
    ) u_core (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .result_o   (core_result),
        .carry_o    (core_carry),
        .overflow_o (core_overflow)
    );

    // FSM plus operand/response registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant0_d || grant1_d) begin
                        op_q    <= grant1_d ? bus.r1_op : bus.r0_op;
                        a_q     <= grant1_d ? bus.r1_a  : bus.r0_a;
                        b_q     <= grant1_d ? bus.r1_b  : bus.r0_b;
                        id_q    <= grant1_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q   <= core_result;
                    rsp_carry_q    <= core_carry;
                    rsp_overflow_q <= core_overflow;
                    rsp_id_q       <= id_q;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ~rsp_id_q;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
